ysyx_210247_trap_csr: RTL and testbench
=======================================

# ysyx_210247_trap_csr

Machine-mode CSR file and trap sequencer for the RV64 core. It sits at commit/writeback, directly upstream of the PC-redirect control logic. It holds mstatus/mie/mip/mtvec/mepc/mcause/mscratch/mcycle, services Zicsr accesses from the committing instruction, and detects ecall, mret and machine-timer interrupts. It then drives a one-cycle `exc_op` pulse together with the updated `csr_mepc`/`csr_mtvec`, from which the redirect logic forms `new_pc`.

## Interface
- `XLEN`, 64: data width (matches `REG_BUS`).
- `clk` input 1: core clock.
- `rst` input 1: asynchronous, active-high reset.
- `inst_valid` input 1: an instruction commits this cycle.
- `inst_pc` input 64: PC of the committing instruction.
- `inst_next_pc` input 64: architectural next PC of the committing instruction (branch-resolved).
- `inst_ecall` input 1: committing instruction is ecall (qualified by `inst_valid`).
- `inst_mret` input 1: committing instruction is mret (qualified by `inst_valid`).
- `csr_op` input 2: 00 none, 01 RW, 10 RS, 11 RC (qualified by `inst_valid`).
- `csr_addr` input 12: CSR address.
- `csr_wdata` input 64: rs1/uimm operand.
- `csr_rdata` output 64: combinational read of `csr_addr`, pre-write value; 0 for unimplemented addresses.
- `timer_irq` input 1: level machine-timer interrupt from CLINT.
- `exc_op` output 32: 0 none, 1 ecall, 2 mret, 3 interrupt. Registered, one-cycle pulse.
- `csr_mepc` output 64: current mepc.
- `csr_mtvec` output 64: current mtvec.
- `trap_busy` output 1: high while `exc_op` ≠ 0. Upstream must flush/stall; commits are ignored.

## Operation
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00. Writes to other addresses are dropped.
- Write value:
  - RW: `csr_wdata`.
  - RS: old | wdata.
  - RC: old & ~wdata.
- Masks:
  - mtvec[1:0] and mepc[1:0] are forced 0 (direct mode only).
  - mstatus writable bits: MIE[3] and MPIE[7]. MPP[12:11] is hardwired 2'b11.
  - mie writable bit: MTIE[7] only.
  - mip is read-only: MTIP[7] = `timer_irq`.
- mcycle increments by 1 every cycle and wraps modulo 2^64. A CSR write to mcycle replaces the increment in that cycle.
- Interrupt pending: `irq_take` = mstatus.MIE & mie.MTIE & `timer_irq` & `inst_valid` & ~`trap_busy`.
- Event priority in a commit cycle: ecall > mret > interrupt. Only one event per cycle.
- Ecall: mepc ← `inst_pc`; mcause ← 11; MPIE ← MIE; MIE ← 0.
- Mret: MIE ← MPIE; MPIE ← 1. mepc is unchanged.
- Interrupt: mepc ← `inst_next_pc`; mcause ← 0x8000_0000_0000_0007; MPIE ← MIE; MIE ← 0. The committing instruction completes, including its CSR write.
- CSR write in the same cycle as an interrupt: the write is applied first, then trap fields overwrite mepc/mcause/mstatus.
- State machine:
  - IDLE: on an event, go to REDIRECT and register `exc_op` = event code.
  - REDIRECT: `exc_op` held for exactly one cycle; `trap_busy` = 1; all inputs ignored (no CSR write, no event). Then return to IDLE with `exc_op` = 0.
- Reset values:
  - mstatus = 0x0000_0000_0000_1800.
  - All other CSRs = 0.
  - `exc_op` = 0, `trap_busy` = 0, state IDLE.
- Reset asserted mid-REDIRECT aborts the pulse immediately (asynchronous).

## Timing
- Event committed in cycle N: CSR updates at the N→N+1 edge.
- In N+1: `exc_op` ≠ 0, `trap_busy` = 1, and `csr_mepc`/`csr_mtvec` already show post-update values. The redirect target is therefore valid in N+1.
- N+2: `exc_op` = 0. A new commit is accepted from N+2.
- `csr_rdata` has zero latency. A read and write to the same CSR in one cycle returns the old value; the new value is visible from the next cycle.
- `timer_irq` is sampled only in commit cycles. Pending level is not latched internally.

## Test plan
- Reset, then read: mstatus reads 0x1800, mcycle counts 0,1,2…, and `exc_op` = 0 throughout reset.
- CSRRW mtvec = 0x8000_0103, then ecall at pc 0x8000_0040 → next cycle `exc_op` = 1, `csr_mtvec` = 0x8000_0100, mepc = 0x8000_0040, mcause = 11, MIE = 0; N+2 `exc_op` = 0.
- Set MIE = 1, then ecall, then mret → `exc_op` = 2, `csr_mepc` = 0x8000_0040, MIE = 1, MPIE = 1.
- MIE = 1, MTIE = 1, `timer_irq` = 1 on commit with `inst_next_pc` = 0x8000_0200 → `exc_op` = 3, mepc = 0x8000_0200, mcause = 0x8000_0000_0000_0007. A commit presented during REDIRECT is ignored.
- Ecall and `timer_irq` in the same commit → only `exc_op` = 1. After mret, the interrupt is taken on the next commit.
- CSRRS/CSRRC on mie with 0xFFFF → only bit 7 changes. Writes to mip and to unimplemented address 0x7C0 are ignored and read back 0. Assert `rst` during REDIRECT → `exc_op` = 0 immediately.

Source files
------------

// File: rtl/ysyx_210247_trap_csr.sv
// Machine-mode CSR file and trap sequencer: services Zicsr accesses at commit and
// raises a one-cycle exc_op pulse (ecall/mret/timer interrupt) for the PC redirect.
module ysyx_210247_trap_csr #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] inst_next_pc,
  input  logic            inst_ecall,
  input  logic            inst_mret,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            timer_irq,
  output logic [31:0]     exc_op,
  output logic [XLEN-1:0] csr_mepc,
  output logic [XLEN-1:0] csr_mtvec,
  output logic            trap_busy
);

  typedef enum logic {IDLE, REDIRECT} state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, {(XLEN-4){1'b0}}, 3'b111};

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;

  state_e          state_q, state_d;
  logic [31:0]     exc_op_q, exc_op_d;
  logic            st_mie_q, st_mie_d;
  logic            st_mpie_q, st_mpie_d;
  logic            mie_mtie_q, mie_mtie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;

  logic            commit, irq_take;
  logic [XLEN-1:0] wval;

  // Only the architecturally live mstatus bits are stored; MPP reads as M-mode.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = st_mpie_q;
        csr_rdata[3]     = st_mie_q;
      end
      A_MIE:      csr_rdata[7] = mie_mtie_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MIP:      csr_rdata[7] = timer_irq;
      A_MCYCLE:   csr_rdata = mcycle_q;
      default:    csr_rdata = '0;
    endcase
  end

  assign commit   = inst_valid & (state_q == IDLE);
  assign irq_take = st_mie_q & mie_mtie_q & timer_irq & commit;

  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = csr_rdata | csr_wdata;
      2'b11:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  always_comb begin
    state_d    = IDLE;
    exc_op_d   = '0;
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_mtie_d = mie_mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + XLEN'(1);

    if (commit && csr_op != 2'b00) begin
      case (csr_addr)
        A_MSTATUS: begin
          st_mie_d  = wval[3];
          st_mpie_d = wval[7];
        end
        A_MIE:      mie_mtie_d = wval[7];
        A_MTVEC:    mtvec_d    = wval & ALIGN_MASK;
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d     = wval & ALIGN_MASK;
        A_MCAUSE:   mcause_d   = wval;
        A_MCYCLE:   mcycle_d   = wval;
        default:    ;
      endcase
    end

    // Trap fields are applied after the CSR write so they take precedence.
    if (commit && inst_ecall) begin
      state_d   = REDIRECT;
      exc_op_d  = 32'd1;
      mepc_d    = inst_pc & ALIGN_MASK;
      mcause_d  = CAUSE_ECALL;
      st_mpie_d = st_mie_d;
      st_mie_d  = 1'b0;
    end else if (commit && inst_mret) begin
      state_d   = REDIRECT;
      exc_op_d  = 32'd2;
      st_mie_d  = st_mpie_d;
      st_mpie_d = 1'b1;
    end else if (irq_take) begin
      state_d   = REDIRECT;
      exc_op_d  = 32'd3;
      mepc_d    = inst_next_pc & ALIGN_MASK;
      mcause_d  = CAUSE_MTI;
      st_mpie_d = st_mie_d;
      st_mie_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      exc_op_q   <= '0;
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_mtie_q <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
    end else begin
      state_q    <= state_d;
      exc_op_q   <= exc_op_d;
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_mtie_q <= mie_mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
    end
  end

  assign exc_op    = exc_op_q;
  assign trap_busy = (state_q == REDIRECT);
  assign csr_mepc  = mepc_q;
  assign csr_mtvec = mtvec_q;

endmodule

// File: tb/tb_ysyx_210247_trap_csr.sv
// Directed + randomized bench for the trap/CSR block against an architectural model.
module tb_ysyx_210247_trap_csr;

  logic        clk, rst;
  logic        inst_valid, inst_ecall, inst_mret, timer_irq;
  logic [63:0] inst_pc, inst_next_pc, csr_wdata, csr_rdata, csr_mepc, csr_mtvec;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] exc_op;
  logic        trap_busy;

  ysyx_210247_trap_csr #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .inst_next_pc(inst_next_pc), .inst_ecall(inst_ecall), .inst_mret(inst_mret),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .timer_irq(timer_irq), .exc_op(exc_op), .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec),
    .trap_busy(trap_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Architectural model: full 64-bit CSR images and the pending pulse code.
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle;
  int          m_exc;

  task automatic model_reset();
    m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_exc = 0;
  endtask

  function automatic logic [63:0] m_read(input logic [11:0] a, input logic irq);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return irq ? 64'h80 : 64'h0;
      12'hB00: return m_mcycle;
      default: return 64'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check read, advance model, check registered outputs.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [63:0] npc,
                     input logic ec, input logic mr, input logic [1:0] op,
                     input logic [11:0] a, input logic [63:0] wd, input logic irq);
    logic [63:0] old, val, nxt_cyc;
    logic        irq_en;
    int          ev;
    inst_valid = v; inst_pc = pc; inst_next_pc = npc; inst_ecall = ec; inst_mret = mr;
    csr_op = op; csr_addr = a; csr_wdata = wd; timer_irq = irq;
    #1;
    chk("csr_rdata", csr_rdata, m_read(a, irq));
    nxt_cyc = m_mcycle + 64'd1;
    ev = 0;
    if (v && m_exc == 0) begin
      irq_en = m_mstatus[3] && m_mie[7] && irq;
      if (op != 2'b00) begin
        old = m_read(a, irq);
        val = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
        case (a)
          12'h300: m_mstatus = 64'h1800 | (val & 64'h88);
          12'h304: m_mie = val & 64'h80;
          12'h305: m_mtvec = val & ~64'h3;
          12'h340: m_mscratch = val;
          12'h341: m_mepc = val & ~64'h3;
          12'h342: m_mcause = val;
          12'hB00: nxt_cyc = val;
          default: ;
        endcase
      end
      if (ec) ev = 1;
      else if (mr) ev = 2;
      else if (irq_en) ev = 3;
      if (ev == 1 || ev == 3) begin
        m_mepc = (ev == 1) ? pc : npc;
        m_mcause = (ev == 1) ? 64'd11 : 64'h8000_0000_0000_0007;
        m_mstatus[7] = m_mstatus[3];
        m_mstatus[3] = 1'b0;
      end else if (ev == 2) begin
        m_mstatus[3] = m_mstatus[7];
        m_mstatus[7] = 1'b1;
      end
    end
    m_exc = ev;
    m_mcycle = nxt_cyc;
    @(posedge clk);
    @(negedge clk);
    chk("exc_op", {32'h0, exc_op}, 64'(m_exc));
    chk("trap_busy", {63'h0, trap_busy}, {63'h0, m_exc != 0});
    chk("csr_mepc", csr_mepc, m_mepc);
    chk("csr_mtvec", csr_mtvec, m_mtvec);
  endtask

  task automatic rd(input logic [11:0] a);
    cyc(1'b1, 64'h0, 64'h4, 1'b0, 1'b0, 2'b00, a, 64'h0, 1'b0);
  endtask

  logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                             12'h342, 12'h344, 12'hB00, 12'h7C0, 12'h300};

  initial begin
    rst = 1'b1;
    inst_valid = 0; inst_pc = 0; inst_next_pc = 0; inst_ecall = 0; inst_mret = 0;
    csr_op = 0; csr_addr = 12'h300; csr_wdata = 0; timer_irq = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_exc_op", {32'h0, exc_op}, 64'h0);
      chk("rst_busy", {63'h0, trap_busy}, 64'h0);
      chk("rst_mstatus", csr_rdata, 64'h1800);
    end
    rst = 1'b0;

    // mcycle counts from zero out of reset
    repeat (3) rd(12'hB00);
    rd(12'h300);

    // mtvec alignment and ecall
    cyc(1, 64'h8000_0000, 64'h8000_0004, 0, 0, 2'b01, 12'h305, 64'h8000_0103, 0);
    cyc(1, 64'h8000_0040, 64'h8000_0044, 1, 0, 2'b00, 12'h342, 64'h0, 0);
    chk("ecall_exc", {32'h0, exc_op}, 64'd1);
    chk("ecall_mtvec", csr_mtvec, 64'h8000_0100);
    chk("ecall_mepc", csr_mepc, 64'h8000_0040);
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b01, 12'h342, 64'hdead, 0);
    chk("ecall_done", {32'h0, exc_op}, 64'd0);
    rd(12'h342);
    rd(12'h300);

    // ecall with MIE=1, then mret restores it
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b10, 12'h300, 64'h8, 0);
    cyc(1, 64'h8000_0040, 64'h8000_0044, 1, 0, 2'b00, 12'h300, 64'h0, 0);
    rd(12'h300);
    cyc(1, 64'h8000_0100, 64'h8000_0104, 0, 1, 2'b00, 12'h300, 64'h0, 0);
    chk("mret_exc", {32'h0, exc_op}, 64'd2);
    chk("mret_mepc", csr_mepc, 64'h8000_0040);
    rd(12'h300);
    chk("mret_mstatus", csr_rdata, 64'h1888);

    // timer interrupt with a same-cycle mscratch write; commit during REDIRECT ignored
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b10, 12'h304, 64'h80, 0);
    cyc(1, 64'h8000_01fc, 64'h8000_0200, 0, 0, 2'b01, 12'h340, 64'h1234, 1);
    chk("irq_exc", {32'h0, exc_op}, 64'd3);
    chk("irq_mepc", csr_mepc, 64'h8000_0200);
    cyc(1, 64'h9000_0000, 64'h9000_0004, 1, 0, 2'b01, 12'h342, 64'h55, 1);
    chk("busy_ignored", {32'h0, exc_op}, 64'd0);
    rd(12'h342);
    chk("irq_mcause", csr_rdata, 64'h8000_0000_0000_0007);
    rd(12'h340);

    // ecall beats a simultaneous interrupt; the interrupt is taken after mret
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b10, 12'h300, 64'h8, 0);
    cyc(1, 64'h8000_0300, 64'h8000_0304, 1, 0, 2'b00, 12'h300, 64'h0, 1);
    chk("prio_exc", {32'h0, exc_op}, 64'd1);
    rd(12'h300);
    cyc(1, 64'h8000_0100, 64'h8000_0104, 0, 1, 2'b00, 12'h300, 64'h0, 0);
    rd(12'h300);
    cyc(1, 64'h8000_0400, 64'h8000_0404, 0, 0, 2'b00, 12'h300, 64'h0, 1);
    chk("irq_after_mret", {32'h0, exc_op}, 64'd3);
    rd(12'h300);

    // mie masking, read-only mip, unimplemented address, mcycle wrap
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b11, 12'h304, 64'hFFFF, 0);
    rd(12'h304);
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b10, 12'h304, 64'hFFFF, 0);
    rd(12'h304);
    chk("mie_mask", csr_rdata, 64'h80);
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b01, 12'h344, 64'hFFFF, 0);
    rd(12'h344);
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b01, 12'h7C0, 64'hFFFF, 0);
    rd(12'h7C0);
    cyc(1, 64'h0, 64'h4, 0, 0, 2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    rd(12'hB00);
    rd(12'hB00);

    // reset during REDIRECT kills the pulse at once
    cyc(1, 64'h8000_0500, 64'h8000_0504, 1, 0, 2'b00, 12'h300, 64'h0, 0);
    rst = 1'b1;
    #1;
    chk("rst_abort_exc", {32'h0, exc_op}, 64'h0);
    chk("rst_abort_busy", {63'h0, trap_busy}, 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rd(12'h300);

    // randomized commits against the model
    for (int i = 0; i < 400; i++) begin
      logic [63:0] pc;
      pc = {$urandom, $urandom} & ~64'h3;
      cyc($urandom_range(0, 9) < 8, pc, pc + 64'd4,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          2'($urandom_range(0, 3)), addrs[$urandom_range(0, 9)],
          ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'(1 << $urandom_range(0, 12)),
          $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
